// File: rtl/song_reader_pkg.sv
// Shared definitions for the song reader: ROM entry layout, entry decode helper and FSM states.
package song_reader_pkg;

  localparam int ENTRY_AW_DEF   = 5;
  localparam int SONG_W_DEF     = 2;
  localparam int NUM_VOICES_DEF = 3;
  localparam int ROM_LATENCY    = 1;

  localparam int TYPE_BIT = 15;
  localparam int NOTE_HI  = 14;
  localparam int NOTE_LO  = 9;
  localparam int DUR_HI   = 8;
  localparam int DUR_LO   = 3;

  localparam logic TYPE_NOTE = 1'b0;
  localparam logic TYPE_WAIT = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ROMWAIT,
    ST_DECODE,
    ST_VSTALL,
    ST_LOAD,
    ST_WAITBT,
    ST_ADVANCE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic       is_wait;
    logic       is_end;
    logic [5:0] note;
    logic [5:0] dur;
  } entry_t;

  // For WAIT entries the dur field carries the beat count.
  function automatic entry_t decode_entry(input logic [TYPE_BIT:DUR_LO] raw);
    entry_t e;
    e.is_wait = (raw[TYPE_BIT] == TYPE_WAIT);
    e.note    = raw[NOTE_HI:NOTE_LO];
    e.dur     = raw[DUR_HI:DUR_LO];
    e.is_end  = (raw[TYPE_BIT] == TYPE_NOTE) && (e.dur == 6'd0);
    return e;
  endfunction

endpackage

// File: rtl/song_reader_if.sv
// Song ROM read port plus note-load port between the song reader (master) and ROM/note player (slave).
interface song_reader_if #(
  parameter int ADDR_W     = song_reader_pkg::SONG_W_DEF + song_reader_pkg::ENTRY_AW_DEF,
  parameter int NUM_VOICES = song_reader_pkg::NUM_VOICES_DEF
);
  logic [ADDR_W-1:0]     rom_addr;
  logic [15:0]           rom_data;
  logic [5:0]            note_to_load;
  logic [5:0]            duration;
  logic                  load_new_note;
  logic [NUM_VOICES-1:0] voice_free;

  modport master (
    output rom_addr, note_to_load, duration, load_new_note,
    input  rom_data, voice_free
  );

  modport slave (
    input  rom_addr, note_to_load, duration, load_new_note,
    output rom_data, voice_free
  );
endinterface

// File: rtl/song_reader_beat_wait_counter.sv
// Beat down-counter for WAIT entries: load, decrement on beat while enabled, terminal-count flags.
module beat_wait_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         play,
  input  logic         en,
  input  logic         beat,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick;

  assign tick = play & en & beat & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (play && load) begin
      cnt_d = load_val;
    end else if (tick) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero   = (cnt_q == '0);
  // The beat that takes the count to zero ends the wait in the same cycle.
  assign expire = tick & (cnt_q == W'(1));

endmodule

// File: rtl/song_reader.sv
// Walks a song ROM and issues note loads to the 3-voice note player, with beat waits and voice stalls.
// Build option SONG_READER_LOOP_EN: END marker or index wrap restarts the song instead of stopping.
//
// state    | meaning
// IDLE     | stopped; latches song select when play rises
// FETCH    | present {song, entry_idx} to the ROM
// ROMWAIT  | ROM read latency
// DECODE   | register entry fields and branch on entry type
// VSTALL   | note pending, waiting for any free voice
// LOAD     | single-cycle load strobe to the note player
// WAITBT   | counting down the beats of a WAIT entry
// ADVANCE  | step to the next entry; wrap past the last entry ends the song
// DONE     | song finished, held until play falls
module song_reader
  import song_reader_pkg::*;
#(
  parameter int ENTRY_AW   = ENTRY_AW_DEF,
  parameter int SONG_W     = SONG_W_DEF,
  parameter int NUM_VOICES = NUM_VOICES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic [SONG_W-1:0] song,
  input  logic              beat,
  song_reader_if.master     bus,
  output logic              activate,
  output logic              song_done
);

  state_e                       state_q, state_d;
  logic [SONG_W-1:0]            song_q, song_d;
  logic [ENTRY_AW-1:0]          entry_idx_q, entry_idx_d;
  logic [SONG_W+ENTRY_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [5:0]                   note_q, note_d;
  logic [5:0]                   dur_q, dur_d;
  logic                         song_done_q, song_done_d;

  entry_t ent;
  logic   end_hit;
  logic   wait_load;
  logic   wait_zero;
  logic   wait_expire;
  logic   unused_rsvd;

  assign ent         = decode_entry(bus.rom_data[TYPE_BIT:DUR_LO]);
  assign unused_rsvd = ^bus.rom_data[DUR_LO-1:0];

  beat_wait_counter #(.W(6)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .play     (play),
    .en       (state_q == ST_WAITBT),
    .beat     (beat),
    .load     (wait_load),
    .load_val (ent.dur),
    .zero     (wait_zero),
    .expire   (wait_expire)
  );

  always_comb begin
    state_d     = state_q;
    song_d      = song_q;
    entry_idx_d = entry_idx_q;
    rom_addr_d  = rom_addr_q;
    note_d      = note_q;
    dur_d       = dur_q;
    song_done_d = 1'b0;
    end_hit     = 1'b0;
    wait_load   = 1'b0;

    // Everything is frozen while paused, except that DONE releases on play falling.
    if (play) begin
      case (state_q)
        ST_IDLE: begin
          song_d      = song;
          entry_idx_d = '0;
          state_d     = ST_FETCH;
        end
        ST_FETCH: begin
          rom_addr_d = {song_q, entry_idx_q};
          state_d    = ST_ROMWAIT;
        end
        ST_ROMWAIT: state_d = ST_DECODE;
        ST_DECODE: begin
          if (ent.is_end) begin
            end_hit = 1'b1;
          end else if (ent.is_wait) begin
            if (ent.dur == 6'd0) begin
              state_d = ST_ADVANCE;
            end else begin
              wait_load = 1'b1;
              state_d   = ST_WAITBT;
            end
          end else begin
            note_d  = ent.note;
            dur_d   = ent.dur;
            state_d = (|bus.voice_free) ? ST_LOAD : ST_VSTALL;
          end
        end
        ST_VSTALL: begin
          if (|bus.voice_free) state_d = ST_LOAD;
        end
        ST_LOAD: state_d = ST_ADVANCE;
        ST_WAITBT: begin
          if (wait_expire || wait_zero) state_d = ST_ADVANCE;
        end
        ST_ADVANCE: begin
          if (&entry_idx_q) begin
            end_hit = 1'b1;
          end else begin
            entry_idx_d = entry_idx_q + 1'b1;
            state_d     = ST_FETCH;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase

      if (end_hit) begin
        song_done_d = 1'b1;
`ifdef SONG_READER_LOOP_EN
        entry_idx_d = '0;
        state_d     = ST_FETCH;
`else
        state_d     = ST_DONE;
`endif
      end
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      song_q      <= '0;
      entry_idx_q <= '0;
      rom_addr_q  <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      song_q      <= song_d;
      entry_idx_q <= entry_idx_d;
      rom_addr_q  <= rom_addr_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      song_done_q <= song_done_d;
    end
  end

  assign bus.rom_addr      = rom_addr_q;
  assign bus.note_to_load  = note_q;
  assign bus.duration      = dur_q;
  // Gated so a pause or a reset landing on LOAD never produces a strobe.
  assign bus.load_new_note = (state_q == ST_LOAD) & play & ~reset;
  assign activate          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign song_done         = song_done_q;

endmodule
